circuito_jogo_param: RTL

Parametrised successor of the fixed 4-switch / 16-play sequence-memory game. The player reproduces a ROM-stored sequence of one-hot switch plays. It adds:
- configurable switch width and sequence depth;
- a per-play timeout;
- a progressive ("Simon") mode in which round r first shows items 0..r on the LEDs, then requires the player to repeat them.

It is the top-level game datapath plus FSM; 7-segment decoding stays in the board wrapper.

---
 rtl/jogo_pkg.sv | 26 ++
 rtl/circuito_jogo_rom_sequencia.sv | 16 +
 rtl/circuito_jogo_param.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised sequence-memory game:
// FSM state codes and helpers for sizing counters from parameters.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        APAGA       = 4'h3,
        ESPERA      = 4'h4,
        COMPARA     = 4'h6,
        PROXIMA     = 4'h7,
        PROX_RODADA = 4'h8,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hC,
        FIM_ERRO    = 4'hE
    } estado_t;

    localparam int unsigned ESTADO_W = 4;

    // Bits needed to count 0..valor-1, never less than one.
    function automatic int unsigned largura(input int unsigned valor);
        return (valor > 1) ? $clog2(valor) : 1;
    endfunction

endpackage

// File: rtl/circuito_jogo_rom_sequencia.sv
// Combinational sequence ROM: item i is the one-hot pattern 1 << (i mod N).
module rom_sequencia
    import jogo_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic [largura(DEPTH)-1:0] addr,
    output logic [N-1:0]              dado
);

    always_comb begin
        dado = N'(1) << (32'(addr) % N);
    end

endmodule

// File: rtl/circuito_jogo_param.sv
// Sequence-memory game: fixed or progressive (Simon) mode, per-play timeout,
// LED display of the sequence; 7-segment decoding lives in the board wrapper.
module circuito_jogo_param
    import jogo_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TIMEOUT    = 3000,
    parameter int unsigned LED_CYCLES = 500
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      modo,
    input  logic [N-1:0]              chaves,
    output logic                      acertou,
    output logic                      errou,
    output logic                      timeout,
    output logic                      pronto,
    output logic [N-1:0]              leds,
    output logic [ESTADO_W-1:0]       db_estado,
    output logic [largura(DEPTH)-1:0] db_endereco,
    output logic [largura(DEPTH)-1:0] db_rodada,
    output logic [N-1:0]              db_jogada,
    output logic                      db_tem_jogada
);

    localparam int unsigned AW = largura(DEPTH);
    localparam int unsigned TW = largura(TIMEOUT);
    localparam int unsigned LW = largura(LED_CYCLES);
    localparam logic [AW-1:0] ULTIMO = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] CMAX   = LW'(LED_CYCLES - 1);

    estado_t       estado_q, estado_d;
    logic [AW-1:0] endereco_q, endereco_d;
    logic [AW-1:0] rodada_q, rodada_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  jogada_q, jogada_d;
    logic          modo_q, modo_d;
    logic          prev_q;
    logic          tem_jogada_q;
    logic [N-1:0]  leds_q, leds_d;
    logic          acertou_q, acertou_d, errou_q, errou_d;
    logic          timeout_q, timeout_d, pronto_q, pronto_d;
    logic          tem_jogada;
    logic [N-1:0]  item_atual, item_proximo;

    assign tem_jogada = (|chaves) & ~prev_q;

    // Two read ports: compare uses the current address while the registered
    // LED output is looked up at the next address, keeping both loop-free.
    rom_sequencia #(.N(N), .DEPTH(DEPTH)) u_rom_cmp (
        .addr (endereco_q),
        .dado (item_atual)
    );

    rom_sequencia #(.N(N), .DEPTH(DEPTH)) u_rom_led (
        .addr (endereco_d),
        .dado (item_proximo)
    );

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        rodada_d   = rodada_q;
        jogada_d   = jogada_q;
        modo_d     = modo_q;
        timer_d    = '0;
        cnt_d      = '0;
        case (estado_q)
            INICIAL: if (iniciar) estado_d = PREPARA;
            PREPARA: begin
                endereco_d = '0;
                jogada_d   = '0;
                modo_d     = modo;
                rodada_d   = modo ? '0 : ULTIMO;
                estado_d   = modo ? MOSTRA : ESPERA;
            end
            MOSTRA: begin
                if (cnt_q == CMAX) estado_d = APAGA;
                else               cnt_d    = cnt_q + LW'(1);
            end
            APAGA: begin
                if (cnt_q != CMAX) begin
                    cnt_d = cnt_q + LW'(1);
                end else if (endereco_q == rodada_q) begin
                    endereco_d = '0;
                    estado_d   = ESPERA;
                end else begin
                    endereco_d = endereco_q + AW'(1);
                    estado_d   = MOSTRA;
                end
            end
            ESPERA: begin
                timer_d = timer_q + TW'(1);
                if (tem_jogada) begin
                    jogada_d = chaves;
                    estado_d = COMPARA;
                end else if (timer_q == TMAX) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            COMPARA: begin
                if (jogada_q != item_atual)                  estado_d = FIM_ERRO;
                else if (endereco_q != rodada_q)             estado_d = PROXIMA;
                else if (!modo_q || rodada_q == ULTIMO)      estado_d = FIM_ACERTO;
                else                                         estado_d = PROX_RODADA;
            end
            PROXIMA: begin
                endereco_d = endereco_q + AW'(1);
                estado_d   = ESPERA;
            end
            PROX_RODADA: begin
                rodada_d   = rodada_q + AW'(1);
                endereco_d = '0;
                estado_d   = MOSTRA;
            end
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: if (iniciar) estado_d = PREPARA;
            default: estado_d = INICIAL;
        endcase

        leds_d    = (estado_d == MOSTRA) ? item_proximo : '0;
        acertou_d = (estado_d == FIM_ACERTO);
        errou_d   = (estado_d == FIM_ERRO);
        timeout_d = (estado_d == FIM_TIMEOUT);
        pronto_d  = acertou_d | errou_d | timeout_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            endereco_q   <= '0;
            rodada_q     <= '0;
            timer_q      <= '0;
            cnt_q        <= '0;
            jogada_q     <= '0;
            modo_q       <= 1'b0;
            prev_q       <= 1'b0;
            tem_jogada_q <= 1'b0;
            leds_q       <= '0;
            acertou_q    <= 1'b0;
            errou_q      <= 1'b0;
            timeout_q    <= 1'b0;
            pronto_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            endereco_q   <= endereco_d;
            rodada_q     <= rodada_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            jogada_q     <= jogada_d;
            modo_q       <= modo_d;
            prev_q       <= |chaves;
            tem_jogada_q <= tem_jogada;
            leds_q       <= leds_d;
            acertou_q    <= acertou_d;
            errou_q      <= errou_d;
            timeout_q    <= timeout_d;
            pronto_q     <= pronto_d;
        end
    end

    assign acertou       = acertou_q;
    assign errou         = errou_q;
    assign timeout       = timeout_q;
    assign pronto        = pronto_q;
    assign leds          = leds_q;
    assign db_estado     = estado_q;
    assign db_endereco   = endereco_q;
    assign db_rodada     = rodada_q;
    assign db_jogada     = jogada_q;
    assign db_tem_jogada = tem_jogada_q;

endmodule
